// File: rtl/cdc_event_arbiter.sv
// Round-robin arbiter that shares one toggle_sync event channel among N_REQ requesters.
// Optional ack timeout is enabled with `define CDC_ARB_TIMEOUT_EN.
module cdc_event_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int TO_W   = 8,
  parameter int TO_MAX = 255
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack_tgl_in,
  output logic             sync_enb,
  output logic [ID_W-1:0]  sync_id,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic             coalesce,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  nxt_ptr;
  logic             found;
  logic [N_REQ-1:0] grant_vec;
  logic             ack_s1, ack_s2, ack_s3;
  logic             ack_evt;

  // The third flop remembers the last synchronized level so each ack toggle yields one pulse.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the flops a true shift chain regardless of order.
      ack_s1 <= ack_tgl_in;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;
    end
  end

  assign ack_evt = ack_s2 ^ ack_s3;

  // The lowest set bit overall is the wrap-around fallback; a set bit at or above rr_ptr overrides it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found  = 1'b0;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i] && (ID_W'(i) >= rr_ptr)) winner = ID_W'(i);
    end
  end

  assign nxt_ptr = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);

  always_comb begin
    grant_vec = '0;
    if (state == IDLE && found) grant_vec[winner] = 1'b1;
  end

  // A request landing on its own grant edge re-arms pending, so that event is not lost.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      pending  <= '0;
      coalesce <= 1'b0;
    end else begin
      pending  <= (pending & ~grant_vec) | req;
      coalesce <= |(req & pending & ~grant_vec);
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sync_id  <= '0;
      sync_enb <= 1'b0;
      busy     <= 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
      to_cnt   <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      sync_enb <= 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            sync_id <= winner;
            rr_ptr  <= nxt_ptr;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          sync_enb <= 1'b1;
`ifdef CDC_ARB_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack arriving on the terminal count wins over the timeout.
          if (ack_evt) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef CDC_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Randomized and directed bench for cdc_event_arbiter against an event-timeline reference model.
// Builds with or without CDC_ARB_TIMEOUT_EN; the timeout expectations follow the macro.
module tb_cdc_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TOW = 8;
  localparam int TOM = 8;

  logic           src_clk    = 1'b0;
  logic           src_rst_n  = 1'b0;
  logic [N-1:0]   req        = '0;
  logic           ack_tgl_in = 1'b0;
  logic           sync_enb;
  logic [IDW-1:0] sync_id;
  logic [N-1:0]   pending;
  logic           busy;
  logic           coalesce;
  logic           timeout;

  cdc_event_arbiter #(.N_REQ(N), .ID_W(IDW), .TO_W(TOW), .TO_MAX(TOM)) dut (
    .src_clk   (src_clk),
    .src_rst_n (src_rst_n),
    .req       (req),
    .ack_tgl_in(ack_tgl_in),
    .sync_enb  (sync_enb),
    .sync_id   (sync_id),
    .pending   (pending),
    .busy      (busy),
    .coalesce  (coalesce),
    .timeout   (timeout)
  );

  always #5 src_clk = ~src_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: pending set, pointer, and edge numbers of the grant and of release.
  bit mp [N];
  int mptr    = 0;
  int mid     = 0;
  int m_g     = -10;
  int m_rel   = -1;
  int m_to    = -10;
  int ack_due = -1;
  int ack_d   = 4;
  bit no_ack  = 1'b0;
  bit spur_tgl = 1'b0;
  int glog[$];
  int coal_seen = 0;
  int to_seen   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gat(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  function automatic bit model_any();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= mp[i];
    return a;
  endfunction

  // One clock: drive at negedge, advance the model on the posedge, compare 1 time unit later.
  task automatic step(input logic [N-1:0] r);
    bit           grant;
    bit           coal;
    int           w;
    logic [N-1:0] pv;
    @(negedge src_clk);
    req = r;
    if (cyc + 1 == ack_due || spur_tgl) ack_tgl_in = ~ack_tgl_in;
    spur_tgl = 1'b0;
    @(posedge src_clk);
    cyc++;
    grant = 1'b0;
    w     = 0;
    if (cyc > m_rel) begin
      for (int k = 0; k < N; k++) begin
        if (!grant && mp[(mptr + k) % N]) begin
          grant = 1'b1;
          w     = (mptr + k) % N;
        end
      end
    end
    coal = 1'b0;
    for (int i = 0; i < N; i++)
      if (r[i] && mp[i] && !(grant && i == w)) coal = 1'b1;
    if (grant) begin
      mp[w] = 1'b0;
      mptr  = (w + 1) % N;
      mid   = w;
      m_g   = cyc;
      if (no_ack) begin
        ack_due = -1;
`ifdef CDC_ARB_TIMEOUT_EN
        m_rel = cyc + 1 + TOM;
        m_to  = m_rel;
`else
        m_rel = 1 << 30;
`endif
      end else begin
        ack_due = cyc + 1 + ack_d;
        m_rel   = ack_due + 2;
      end
    end
    for (int i = 0; i < N; i++) if (r[i]) mp[i] = 1'b1;
    #1;
    for (int i = 0; i < N; i++) pv[i] = mp[i];
    check("pending",  32'(pending),  32'(pv));
    check("sync_enb", 32'(sync_enb), 32'(cyc == m_g + 1));
    check("sync_id",  32'(sync_id),  32'(mid));
    check("busy",     32'(busy),     32'(cyc < m_rel));
    check("coalesce", 32'(coalesce), 32'(coal));
    check("timeout",  32'(timeout),  32'(cyc == m_to));
    if (sync_enb) glog.push_back(int'(sync_id));
    if (coalesce) coal_seen++;
    if (timeout)  to_seen++;
  endtask

  task automatic drain();
    int n = 0;
    while ((cyc < m_rel || model_any()) && n < 200) begin
      step('0);
      n++;
    end
    check("drain_bound", 32'(n < 200), 32'(1));
  endtask

  // Called just after a compare point; asserts reset mid-cycle and checks the async clear.
  task automatic do_reset(input string tag);
    #2 src_rst_n = 1'b0;
    #1;
    check({tag, "_enb"},  32'(sync_enb), 32'(0));
    check({tag, "_id"},   32'(sync_id),  32'(0));
    check({tag, "_pend"}, 32'(pending),  32'(0));
    check({tag, "_busy"}, 32'(busy),     32'(0));
    check({tag, "_coal"}, 32'(coalesce), 32'(0));
    check({tag, "_to"},   32'(timeout),  32'(0));
    req        = '0;
    ack_tgl_in = 1'b0;
    for (int i = 0; i < N; i++) mp[i] = 1'b0;
    mptr = 0; mid = 0; m_g = -10; m_rel = -1; m_to = -10; ack_due = -1;
    no_ack = 1'b0;
    @(posedge src_clk);
    #1 src_rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int c0;
    repeat (2) @(posedge src_clk);
    #1;
    do_reset("rst");

    // Full request burst from rr_ptr=0, then 1001 after the pointer wraps.
    glog.delete();
    ack_d = 4;
    step(4'b1111);
    drain();
    check("rr_n", 32'(glog.size()), 32'(4));
    for (int i = 0; i < 4; i++) check("rr_order", 32'(gat(i)), 32'(i));
    glog.delete();
    step(4'b1001);
    drain();
    check("rr2_n",  32'(glog.size()), 32'(2));
    check("rr2_a",  32'(gat(0)), 32'(0));
    check("rr2_b",  32'(gat(1)), 32'(3));

    // Single request with ack 4 cycles after sync_enb.
    glog.delete();
    step(4'b0100);
    drain();
    check("single_n",    32'(glog.size()), 32'(1));
    check("single_id",   32'(gat(0)), 32'(2));
    check("single_pend", 32'(pending), 32'(0));
    check("single_busy", 32'(busy), 32'(0));

    // Two req[1] pulses while id 0 waits for ack: one coalesce, one grant of id 1.
    glog.delete();
    c0    = coal_seen;
    ack_d = 6;
    step(4'b0001);
    step('0);
    step(4'b0010);
    step(4'b0010);
    drain();
    check("coal_pulses", 32'(coal_seen - c0), 32'(1));
    check("coal_n",      32'(glog.size()), 32'(2));
    check("coal_first",  32'(gat(0)), 32'(0));
    check("coal_second", 32'(gat(1)), 32'(1));

    // req[2] on its own grant edge must be granted a second time.
    glog.delete();
    ack_d = 3;
    step(4'b0100);
    step(4'b0100);
    check("same_edge_pend", 32'(pending[2]), 32'(1));
    drain();
    check("same_edge_n", 32'(glog.size()), 32'(2));
    check("same_edge_a", 32'(gat(0)), 32'(2));
    check("same_edge_b", 32'(gat(1)), 32'(2));

    // Spurious ack toggle while idle is ignored; a normal grant follows.
    glog.delete();
    spur_tgl = 1'b1;
    repeat (6) step('0);
    check("spur_none", 32'(glog.size()), 32'(0));
    step(4'b1000);
    drain();
    check("spur_grant", 32'(gat(0)), 32'(3));

    // Randomized traffic with random ack delays.
    for (int n = 0; n < 600; n++) begin
      ack_d = int'($urandom_range(1, 4));
      step(N'($urandom & $urandom & $urandom));
    end
    drain();

    // No ack: timeout (when built with it), then reset while waiting for ack.
    glog.delete();
    no_ack = 1'b1;
    c0     = to_seen;
    step(4'b0010);
    repeat (12) step('0);
`ifdef CDC_ARB_TIMEOUT_EN
    check("to_pulses", 32'(to_seen - c0), 32'(1));
    check("to_idle",   32'(busy), 32'(0));
`else
    check("to_pulses", 32'(to_seen - c0), 32'(0));
    check("to_stuck",  32'(busy), 32'(1));
`endif
    step(4'b0100);
    repeat (4) step('0);
    do_reset("rst_wait");
    glog.delete();
    ack_d = 4;
    step(4'b0001);
    drain();
    check("post_rst_n",  32'(glog.size()), 32'(1));
    check("post_rst_id", 32'(gat(0)), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
